// File: rtl/sp_ram_pkg.sv
// Shared types and helpers for the byte-lane single-port RAM.
package sp_ram_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      IDLE  = 1'b1
   } state_t;

   function automatic int lane_count(input int data_w, input int lane_w);
      return data_w / lane_w;
   endfunction

endpackage

// File: rtl/sp_ram_rd_pipe.sv
// Read-return delay line: READ_LAT register stages carrying rdata/rvalid.
// Data in every stage only moves with a valid, so the output holds its last read.
module sp_ram_rd_pipe #(
   parameter int DATA_W   = 8,
   parameter int READ_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              valid_i,
   input  logic [DATA_W-1:0] data_i,
   output logic              valid_o,
   output logic [DATA_W-1:0] data_o
);

   logic [READ_LAT-1:0]             valid_q;
   logic [READ_LAT-1:0][DATA_W-1:0] data_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         data_q  <= '0;
      end else begin
         valid_q[0] <= valid_i;
         if (valid_i) begin
            data_q[0] <= data_i;
         end
         for (int s = 1; s < READ_LAT; s++) begin
            valid_q[s] <= valid_q[s-1];
            if (valid_q[s-1]) begin
               data_q[s] <= data_q[s-1];
            end
         end
      end
   end

   assign valid_o = valid_q[READ_LAT-1];
   assign data_o  = data_q[READ_LAT-1];

endmodule

// File: rtl/sp_ram_param.sv
// Single-port RAM with per-lane write enables, zero-clear sequencer after reset
// or on request, and a configurable 1- or 2-cycle read return.
module sp_ram_param
   import sp_ram_pkg::*;
#(
   parameter int DATA_W   = 8,
   parameter int LANE_W   = 8,
   parameter int ADDR_W   = 6,
   parameter int DEPTH    = 64,
   parameter int READ_LAT = 1
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                req,
   input  logic                                we,
   input  logic [ADDR_W-1:0]                   addr,
   input  logic [DATA_W-1:0]                   wdata,
   input  logic [lane_count(DATA_W,LANE_W)-1:0] be,
   input  logic                                clr,
   output logic                                ready,
   output logic [DATA_W-1:0]                   rdata,
   output logic                                rvalid
);

   localparam int                LANES     = lane_count(DATA_W, LANE_W);
   localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(DEPTH - 1);

   if ((LANE_W < 1) || ((DATA_W % LANE_W) != 0)) begin : g_bad_lane
      $fatal(1, "sp_ram_param: DATA_W must be a multiple of LANE_W");
   end
   if ((DEPTH < 1) || (DEPTH > (2 ** ADDR_W))) begin : g_bad_depth
      $fatal(1, "sp_ram_param: DEPTH out of range");
   end
   if ((READ_LAT != 1) && (READ_LAT != 2)) begin : g_bad_lat
      $fatal(1, "sp_ram_param: READ_LAT must be 1 or 2");
   end

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic              accept;
   logic              in_range;
   logic              wr_en;
   logic              rd_en;
   logic              clr_wr;
   logic [DATA_W-1:0] rd_word;

   assign ready    = (state_q == IDLE);
   assign accept   = req & ready & ~clr;
   assign in_range = ({1'b0, addr} < DEPTH_L);
   assign wr_en    = accept & we & in_range;
   assign rd_en    = accept & ~we;
   // Memory has no reset; clear writes are held off while reset is asserted.
   assign clr_wr   = (state_q == CLEAR) & rst_n;

   for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [LANE_W-1:0] mem_q [DEPTH];

      always_ff @(posedge clk) begin
         if (clr_wr) begin
            mem_q[cnt_q] <= '0;
         end else if (wr_en && be[gi]) begin
            mem_q[addr] <= wdata[gi*LANE_W +: LANE_W];
         end
      end

      assign rd_word[gi*LANE_W +: LANE_W] = in_range ? mem_q[addr] : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= CLEAR;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         CLEAR: begin
            if (cnt_q == LAST_WORD) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         IDLE: begin
            if (clr) begin
               state_d = CLEAR;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = CLEAR;
            cnt_d   = '0;
         end
      endcase
   end

   sp_ram_rd_pipe #(
      .DATA_W   (DATA_W),
      .READ_LAT (READ_LAT)
   ) u_rd_pipe (
      .clk     (clk),
      .rst_n   (rst_n),
      .valid_i (rd_en),
      .data_i  (rd_word),
      .valid_o (rvalid),
      .data_o  (rdata)
   );

endmodule

// File: tb/tb_sp_ram_param.sv
// Directed bench: two RAM instances (read latency 1 and 2) driven with identical stimulus.
module tb_sp_ram_param;

   logic        clk = 1'b0;
   logic        rst_n, req, we, clr;
   logic [5:0]  addr;
   logic [15:0] wdata;
   logic [1:0]  be;
   logic        ready1, rvalid1, ready2, rvalid2;
   logic [15:0] rdata1, rdata2;

   int          checks = 0;
   int          errors = 0;
   logic [15:0] model [48];

   always #5 clk = ~clk;

   sp_ram_param #(
      .DATA_W(16), .LANE_W(8), .ADDR_W(6), .DEPTH(48), .READ_LAT(1)
   ) u_dut_l1 (
      .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .be(be), .clr(clr), .ready(ready1), .rdata(rdata1), .rvalid(rvalid1)
   );

   sp_ram_param #(
      .DATA_W(16), .LANE_W(8), .ADDR_W(6), .DEPTH(48), .READ_LAT(2)
   ) u_dut_l2 (
      .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .be(be), .clr(clr), .ready(ready2), .rdata(rdata2), .rvalid(rvalid2)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " ready L1"},  32'(ready1),  32'd0);
      check({tag, " rvalid L1"}, 32'(rvalid1), 32'd0);
      check({tag, " rdata L1"},  32'(rdata1),  32'd0);
      check({tag, " ready L2"},  32'(ready2),  32'd0);
      check({tag, " rvalid L2"}, 32'(rvalid2), 32'd0);
      check({tag, " rdata L2"},  32'(rdata2),  32'd0);
   endtask

   // Samples from the current negedge on; optionally pulses clr mid-clear.
   task automatic count_not_ready(input string tag, input bit poke_clr);
      int n1 = 0;
      int n2 = 0;
      for (int i = 0; i < 200; i++) begin
         if (!ready1) n1++;
         if (!ready2) n2++;
         if (ready1 && ready2) break;
         clr = poke_clr && (i >= 10) && (i <= 12);
         @(negedge clk);
      end
      clr = 1'b0;
      check({tag, " low cycles L1"}, 32'(n1), 32'd48);
      check({tag, " low cycles L2"}, 32'(n2), 32'd48);
      $display("txn clear %s ready low L1=%0d L2=%0d", tag, n1, n2);
   endtask

   task automatic do_write(input logic [5:0] a, input logic [15:0] d, input logic [1:0] b);
      req = 1'b1; we = 1'b1; addr = a; wdata = d; be = b;
      @(negedge clk);
      req = 1'b0; we = 1'b0;
      check("wr no rvalid L1", 32'(rvalid1), 32'd0);
      check("wr no rvalid L2", 32'(rvalid2), 32'd0);
      if (a < 6'd48) begin
         if (b[0]) model[a][7:0]  = d[7:0];
         if (b[1]) model[a][15:8] = d[15:8];
      end
      $display("txn write addr=%0d data=0x%04h be=%b", a, d, b);
   endtask

   task automatic do_read(input logic [5:0] a, input logic [15:0] exp);
      req = 1'b1; we = 1'b0; addr = a;
      @(negedge clk);
      req = 1'b0;
      check("rd rvalid L1 +1", 32'(rvalid1), 32'd1);
      check("rd rdata L1",     32'(rdata1),  32'(exp));
      check("rd rvalid L2 +1", 32'(rvalid2), 32'd0);
      @(negedge clk);
      check("rd rvalid L1 +2", 32'(rvalid1), 32'd0);
      check("rd hold L1",      32'(rdata1),  32'(exp));
      check("rd rvalid L2 +2", 32'(rvalid2), 32'd1);
      check("rd rdata L2",     32'(rdata2),  32'(exp));
      $display("txn read addr=%0d L1=0x%04h L2=0x%04h exp=0x%04h", a, rdata1, rdata2, exp);
   endtask

   initial begin
      rst_n = 1'b0; req = 1'b0; we = 1'b0; clr = 1'b0;
      addr = '0; wdata = '0; be = '0;
      for (int i = 0; i < 48; i++) model[i] = 16'h0000;

      // Reset and power-up clear
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst_n = 1'b1;
      count_not_ready("power_up", 1'b0);
      do_read(6'd47, 16'h0000);

      // Byte enables with read straight after the write
      do_write(6'd5, 16'hABCD, 2'b11);
      do_write(6'd5, 16'h1200, 2'b10);
      do_read(6'd5, 16'h12CD);

      // Streaming reads, one per cycle
      do_write(6'd1, 16'h0001, 2'b11);
      do_write(6'd2, 16'h0002, 2'b11);
      do_write(6'd3, 16'h0003, 2'b11);
      req = 1'b1; we = 1'b0; addr = 6'd1;
      @(negedge clk);
      check("stream L1 v0", 32'(rvalid1), 32'd1);
      check("stream L1 d0", 32'(rdata1),  32'h0001);
      check("stream L2 v0", 32'(rvalid2), 32'd0);
      addr = 6'd2;
      @(negedge clk);
      check("stream L1 v1", 32'(rvalid1), 32'd1);
      check("stream L1 d1", 32'(rdata1),  32'h0002);
      check("stream L2 v1", 32'(rvalid2), 32'd1);
      check("stream L2 d1", 32'(rdata2),  32'h0001);
      addr = 6'd3;
      @(negedge clk);
      req = 1'b0;
      check("stream L1 v2", 32'(rvalid1), 32'd1);
      check("stream L1 d2", 32'(rdata1),  32'h0003);
      check("stream L2 v2", 32'(rvalid2), 32'd1);
      check("stream L2 d2", 32'(rdata2),  32'h0002);
      @(negedge clk);
      check("stream L1 v3", 32'(rvalid1), 32'd0);
      check("stream L2 v3", 32'(rvalid2), 32'd1);
      check("stream L2 d3", 32'(rdata2),  32'h0003);
      @(negedge clk);
      check("stream L2 v4", 32'(rvalid2), 32'd0);
      $display("txn stream reads addr=1,2,3");

      // Out-of-range write is dropped; out-of-range read returns zero
      do_write(6'd50, 16'hFFFF, 2'b11);
      do_read(6'd50, 16'h0000);
      for (int i = 0; i < 48; i++) begin
         do_read(6'(i), model[i]);
      end

      // clr and req together: clear wins, write dropped, clr mid-clear ignored
      do_write(6'd0, 16'h00AA, 2'b11);
      clr = 1'b1; req = 1'b1; we = 1'b1; addr = 6'd0; wdata = 16'h5555; be = 2'b11;
      @(negedge clk);
      clr = 1'b0; req = 1'b0; we = 1'b0;
      count_not_ready("clr_collide", 1'b1);
      for (int i = 0; i < 48; i++) model[i] = 16'h0000;
      do_read(6'd0, 16'h0000);
      do_read(6'd5, 16'h0000);

      // Reset in the middle of a clear restarts the whole clear
      do_write(6'd7, 16'hBEEF, 2'b11);
      do_read(6'd7, 16'hBEEF);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      repeat (20) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("mid_clear_reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      count_not_ready("after_mid_reset", 1'b0);
      do_read(6'd7, 16'h0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sp_ram_param.md
SP_RAM_PARAM -- requirements
Module: sp_ram_param

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- DATA_W, 8, word width; a multiple of LANE_W
- LANE_W, 8, byte-enable lane width
- ADDR_W, 6, address width
- DEPTH, 64, implemented words; 1 <= DEPTH <= 2**ADDR_W
- READ_LAT, 1, read latency in cycles; legal values 1 or 2
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk  in  1  single clock; all state changes on the rising edge
- rst_n  in  1  reset; asynchronous assert, active-low
- req  in  1  access request
- we  in  1  1 = write, 0 = read
- addr  in  ADDR_W  word address
- wdata  in  DATA_W  write data
- be  in  DATA_W/LANE_W  per-lane write enable
- clr  in  1  request a full-memory zero clear
- ready  out  1  accepting requests
- rdata  out  DATA_W  read data
- rvalid  out  1  one-cycle pulse marking rdata valid

Function
REQ-003 Accept SHALL equal req & ready & ~clr; no other request has any effect.
REQ-004 An accepted write SHALL update, at the accepting edge, only the lanes of memory[addr] whose be bit is 1.
REQ-005 An accepted write SHALL NOT change rdata or rvalid.
REQ-006 For an accepted read, rdata SHALL show memory[addr] as sampled at the accepting edge, and rvalid SHALL be 1 for exactly one cycle, READ_LAT cycles after that edge.
REQ-007 When no read completes, rdata SHALL hold its last value.
REQ-008 Back-to-back reads SHALL be accepted every cycle, with throughput 1 per cycle at either latency.
REQ-009 A read issued the cycle after a write to the same address SHALL return the newly written lanes merged with the unchanged lanes.
REQ-010 An address >= DEPTH SHALL behave as follows: write dropped; read returns all-zero rdata with normal rvalid timing.
REQ-011 The FSM SHALL have two states:
- CLEAR: ready=0; a counter writes zero to words 0..DEPTH-1, one word per cycle; after the word DEPTH-1 write, go to IDLE.
- IDLE: ready=1; clr=1 goes to CLEAR with the counter at 0.
REQ-012 A clear SHALL take exactly DEPTH cycles, and ready SHALL rise on the cycle after the final clear write.
REQ-013 When clr and req are both asserted in IDLE, clr SHALL win, and the request SHALL be dropped with no memory change.
REQ-014 clr asserted during CLEAR SHALL be ignored and SHALL NOT restart the counter.
REQ-015 Reads accepted before a clear starts SHALL complete with pre-clear data, at normal latency.

Reset
REQ-016 While rst_n=0 the outputs SHALL be: ready=0, rvalid=0, rdata=0, read pipeline empty, FSM in CLEAR, counter 0.
REQ-017 Memory contents SHALL NOT be asynchronously reset; zeroing SHALL come only from the CLEAR sequence that starts on the first edge after rst_n rises.
REQ-018 Reset asserted mid-clear or mid-read SHALL abort the operation, and the full clear SHALL restart from word 0 after release.

Structure
REQ-019 Shared package sp_ram_pkg SHALL hold:
- the state typedef {CLEAR, IDLE}
- a function computing the lane count DATA_W/LANE_W
REQ-020 Parameter legality (DATA_W % LANE_W, DEPTH range, READ_LAT in {1,2}) SHALL be checked at elaboration, and a violation SHALL be fatal.
REQ-021 The READ_LAT-stage rdata/rvalid delay line SHALL be one sub-module, sp_ram_rd_pipe; all else stays in sp_ram_param.

Verification
Bench configuration: DATA_W=16, LANE_W=8, ADDR_W=6, DEPTH=48; each scenario runs at READ_LAT=1 and at READ_LAT=2.
REQ-022 Scenario, reset and clear: release rst_n -> ready=0 for exactly 48 cycles, then 1; a read of addr 47 returns 0x0000.
REQ-023 Scenario, byte enables: write 0xABCD to addr 5 with be=11, then write 0x1200 with be=10, then read addr 5 -> rdata=0x12CD, rvalid exactly READ_LAT cycles after accept.
REQ-024 Scenario, streaming reads: reads of addr 1,2,3 on consecutive cycles (contents 0x0001, 0x0002, 0x0003) -> three consecutive rvalid pulses carrying 0x0001, 0x0002, 0x0003 in order.
REQ-025 Scenario, out-of-range: write 0xFFFF to addr 50, then read addr 50 -> rdata=0x0000 and no in-range word changed.
REQ-026 Scenario, clr collision: in IDLE assert clr and req (write 0x5555 to addr 0) together -> write dropped, ready=0 for 48 cycles, a read of addr 0 returns 0x0000.
REQ-027 Scenario, reset mid-clear: pull rst_n low at clear count 20, release -> ready stays 0 for a full 48 cycles after release.
